// File: rtl/pc_source_unit.sv
// Program counter register with a parameterised source mux, conditional write,
// misaligned-target exception, sticky illegal-select flag and an update counter.
module pc_source_unit #(
   parameter int              WIDTH        = 32,
   parameter int              NSRC         = 6,
   parameter int              SELW         = 3,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = 'hFC
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [SELW-1:0]       pc_source,
   input  logic                  pc_write,
   input  logic                  pc_write_cond,
   input  logic                  cond_true,
   input  logic                  err_clear,
   output logic [WIDTH-1:0]      pc,
   output logic [WIDTH-1:0]      pc_prev,
   output logic [WIDTH-1:0]      bad_addr,
   output logic                  exc,
   output logic                  sel_err,
   output logic [15:0]           upd_count
);

   logic             write_en;
   logic             sel_bad;
   logic             misaligned;
   logic [WIDTH-1:0] target;

   assign write_en   = pc_write | (pc_write_cond & cond_true);
   assign sel_bad    = (32'(pc_source) >= NSRC);
   assign misaligned = (target[1:0] != 2'b00);

   // Out-of-range selects yield zero; they never reach the PC anyway.
   always_comb begin
      target = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (32'(pc_source) == k) begin
            target = src_data[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_VECTOR;
         pc_prev   <= RESET_VECTOR;
         bad_addr  <= '0;
         exc       <= 1'b0;
         sel_err   <= 1'b0;
         upd_count <= 16'd0;
      end else begin
         exc <= 1'b0;
         if (write_en && !sel_bad) begin
            pc_prev   <= pc;
            upd_count <= upd_count + 16'd1;
            if (misaligned) begin
               pc       <= EXC_VECTOR;
               bad_addr <= target;
               exc      <= 1'b1;
            end else begin
               pc <= target;
            end
         end
         // A new illegal write outranks a simultaneous clear.
         if (write_en && sel_bad) begin
            sel_err <= 1'b1;
         end else if (err_clear) begin
            sel_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pc_source_unit.sv
// Directed-vector bench for pc_source_unit: the driver pushes hand-computed
// expected state per clock edge; a monitor pops and compares on the falling edge.
module tb_pc_source_unit;

   localparam int W = 32;
   localparam int N = 6;

   typedef struct packed {
      logic          chk;
      logic [W-1:0]  pc;
      logic [W-1:0]  prev;
      logic [W-1:0]  bad;
      logic          exc;
      logic          sel;
      logic [15:0]   cnt;
   } exp_t;

   logic            clk;
   logic            reset;
   logic [N*W-1:0]  src_data;
   logic [2:0]      pc_source;
   logic            pc_write;
   logic            pc_write_cond;
   logic            cond_true;
   logic            err_clear;
   logic [W-1:0]    pc;
   logic [W-1:0]    pc_prev;
   logic [W-1:0]    bad_addr;
   logic            exc;
   logic            sel_err;
   logic [15:0]     upd_count;

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;

   pc_source_unit dut (
      .clk           (clk),
      .reset         (reset),
      .src_data      (src_data),
      .pc_source     (pc_source),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .cond_true     (cond_true),
      .err_clear     (err_clear),
      .pc            (pc),
      .pc_prev       (pc_prev),
      .bad_addr      (bad_addr),
      .exc           (exc),
      .sel_err       (sel_err),
      .upd_count     (upd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // Monitor: every edge the driver issued has one entry due by the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.chk) begin
            check("pc",        pc,              e.pc);
            check("pc_prev",   pc_prev,         e.prev);
            check("bad_addr",  bad_addr,        e.bad);
            check("exc",       W'(exc),         W'(e.exc));
            check("sel_err",   W'(sel_err),     W'(e.sel));
            check("upd_count", W'(upd_count),   W'(e.cnt));
         end
      end
   end

   task automatic set_src(input int k, input logic [W-1:0] v);
      src_data[k*W +: W] = v;
   endtask

   task automatic step(input logic rst, input logic w, input logic wc, input logic ct,
                       input logic ec, input logic [2:0] sel,
                       input logic [W-1:0] e_pc, input logic [W-1:0] e_prev,
                       input logic [W-1:0] e_bad, input logic e_exc, input logic e_sel,
                       input logic [15:0] e_cnt, input logic chk);
      exp_t e;
      reset         = rst;
      pc_write      = w;
      pc_write_cond = wc;
      cond_true     = ct;
      err_clear     = ec;
      pc_source     = sel;
      e = '{chk: chk, pc: e_pc, prev: e_prev, bad: e_bad, exc: e_exc, sel: e_sel, cnt: e_cnt};
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   initial begin
      reset = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0; cond_true = 1'b0;
      err_clear = 1'b0; pc_source = 3'd0; src_data = '0;
      @(posedge clk); #1;

      //    rst w  wc ct ec sel  pc        prev      bad       exc sel cnt
      step(1, 0, 0, 0, 0, 3'd0, 32'h0,    32'h0,    32'h0,    0,  0,  16'd0, 1);
      set_src(3, 32'h0000_1000);
      step(0, 1, 0, 0, 0, 3'd3, 32'h1000, 32'h0,    32'h0,    0,  0,  16'd1, 1);
      // Select changes without a write are ignored.
      step(0, 0, 0, 0, 0, 3'd5, 32'h1000, 32'h0,    32'h0,    0,  0,  16'd1, 1);
      set_src(1, 32'h0000_2000);
      step(0, 0, 1, 0, 0, 3'd1, 32'h1000, 32'h0,    32'h0,    0,  0,  16'd1, 1);
      step(0, 0, 1, 1, 0, 3'd1, 32'h2000, 32'h1000, 32'h0,    0,  0,  16'd2, 1);
      set_src(2, 32'h0000_1002);
      step(0, 1, 0, 0, 0, 3'd2, 32'hFC,   32'h2000, 32'h1002, 1,  0,  16'd3, 1);
      step(0, 0, 0, 0, 0, 3'd2, 32'hFC,   32'h2000, 32'h1002, 0,  0,  16'd3, 1);
      // Back-to-back exceptions.
      set_src(4, 32'h0000_2001);
      step(0, 1, 0, 0, 0, 3'd4, 32'hFC,   32'hFC,   32'h2001, 1,  0,  16'd4, 1);
      set_src(5, 32'h0000_3003);
      step(0, 1, 0, 0, 0, 3'd5, 32'hFC,   32'hFC,   32'h3003, 1,  0,  16'd5, 1);
      // Illegal selects, sticky flag, clear, and set-wins.
      step(0, 1, 0, 0, 0, 3'd7, 32'hFC,   32'hFC,   32'h3003, 0,  1,  16'd5, 1);
      step(0, 0, 0, 0, 0, 3'd7, 32'hFC,   32'hFC,   32'h3003, 0,  1,  16'd5, 1);
      step(0, 0, 0, 0, 1, 3'd7, 32'hFC,   32'hFC,   32'h3003, 0,  0,  16'd5, 1);
      step(0, 1, 0, 0, 1, 3'd6, 32'hFC,   32'hFC,   32'h3003, 0,  1,  16'd5, 1);
      step(0, 0, 0, 0, 1, 3'd6, 32'hFC,   32'hFC,   32'h3003, 0,  0,  16'd5, 1);
      step(0, 0, 1, 1, 0, 3'd7, 32'hFC,   32'hFC,   32'h3003, 0,  1,  16'd5, 1);
      step(0, 0, 1, 0, 1, 3'd7, 32'hFC,   32'hFC,   32'h3003, 0,  0,  16'd5, 1);
      step(0, 0, 0, 0, 0, 3'd0, 32'hFC,   32'hFC,   32'h3003, 0,  0,  16'd5, 1);
      // Reset beats a simultaneous write.
      set_src(0, 32'h0000_3000);
      step(1, 1, 0, 0, 0, 3'd0, 32'h0,    32'h0,    32'h0,    0,  0,  16'd0, 1);
      step(0, 1, 0, 0, 0, 3'd0, 32'h3000, 32'h0,    32'h0,    0,  0,  16'd1, 1);
      // Reset beats a simultaneous exception and the illegal-select flag.
      step(0, 1, 0, 0, 0, 3'd7, 32'h3000, 32'h0,    32'h0,    0,  1,  16'd1, 1);
      step(1, 1, 0, 0, 1, 3'd2, 32'h0,    32'h0,    32'h0,    0,  0,  16'd0, 1);

      // Counter wrap: 65535 writes reach 0xFFFF, one more wraps to zero.
      set_src(0, 32'h0000_4000);
      for (int i = 1; i <= 65535; i++) begin
         step(0, 1, 0, 0, 0, 3'd0, 32'h4000, (i == 1) ? 32'h0 : 32'h4000, 32'h0, 0, 0,
              16'(i), (i <= 2) || (i >= 65533));
      end
      step(0, 1, 0, 0, 0, 3'd0, 32'h4000, 32'h4000, 32'h0,    0,  0,  16'd0, 1);
      set_src(1, 32'h0000_4001);
      step(0, 0, 1, 1, 0, 3'd1, 32'hFC,   32'h4000, 32'h4001, 1,  0,  16'd1, 1);
      step(0, 0, 0, 0, 0, 3'd1, 32'hFC,   32'h4000, 32'h4001, 0,  0,  16'd1, 1);

      for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
